// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encodings, oversampling ratio
// and default frame geometry. The receiver imports the same package.
package uart_pkg;

  // Oversampling ratio of the shared baud tick.
  localparam int NTICK             = 16;
  localparam int DEFAULT_DATA_BITS = 8;
  localparam int DEFAULT_STOP_BITS = 1;

  // One-hot transmitter states.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } tx_state_t;

endpackage

// File: rtl/tx_uart.sv
// UART transmitter: serialises one word as start bit, DATA_BITS data bits
// (LSB first) and STOP_BITS stop bits, timed by an external 16x baud tick.
module tx_uart
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int STOP_BITS = DEFAULT_STOP_BITS
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_tx,
  output logic                 o_tx_done,
  output logic                 o_busy
);

  localparam int TICK_W = $clog2(NTICK * STOP_BITS) + 1;
  localparam int BIT_W  = $clog2(DATA_BITS) + 1;

  // Terminal counts for a data/start bit, the whole stop period and the last data bit.
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(NTICK - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(NTICK * STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);

  tx_state_t            state_reg;
  logic [TICK_W-1:0]    tick_cnt_reg;
  logic [BIT_W-1:0]     bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 tx_reg;
  logic                 done_reg;
  logic [DATA_BITS-1:0] shift_next;

  // Word after dropping the bit that has just been sent.
  assign shift_next = shift_reg >> 1;

  // Frame sequencer: all state, counters and the serial line advance only on i_tick.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_reg    <= ST_IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          tx_reg <= 1'b1;
          // The tick is deliberately ignored in the accept cycle.
          if (i_tx_start) begin
            shift_reg    <= i_data;
            tick_cnt_reg <= '0;
            tx_reg       <= 1'b0;
            state_reg    <= ST_START;
          end
        end
        ST_START: begin
          if (i_tick) begin
            if (tick_cnt_reg == BIT_LAST) begin
              tick_cnt_reg <= '0;
              bit_cnt_reg  <= '0;
              tx_reg       <= shift_reg[0];
              state_reg    <= ST_DATA;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (i_tick) begin
            if (tick_cnt_reg == BIT_LAST) begin
              tick_cnt_reg <= '0;
              shift_reg    <= shift_next;
              if (bit_cnt_reg == DATA_LAST) begin
                tx_reg    <= 1'b1;
                state_reg <= ST_STOP;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                tx_reg      <= shift_next[0];
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (i_tick) begin
            if (tick_cnt_reg == STOP_LAST) begin
              tick_cnt_reg <= '0;
              done_reg     <= 1'b1;
              state_reg    <= ST_IDLE;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          // Corrupted encoding: drop any partial frame and idle the line.
          state_reg    <= ST_IDLE;
          tick_cnt_reg <= '0;
          bit_cnt_reg  <= '0;
          tx_reg       <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx      = tx_reg;
  assign o_tx_done = done_reg;
  assign o_busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_tx_uart.sv
// Directed self-checking bench for tx_uart: an 8N1 instance and a 7-data/2-stop
// instance share the clock, reset and a tick that fires every 4 clocks.
module tb_tx_uart;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic [6:0] data_b = 7'h00;
  logic       tx_a, done_a, busy_a;
  logic       tx_b, done_b, busy_b;
  logic       sel_b = 1'b0;
  logic       tx_s, done_s, busy_s;

  int compared = 0;
  int mismatched = 0;
  int tcnt = 0;

  tx_uart #(.DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_tx_start(start_a),
    .i_data(data_a), .o_tx(tx_a), .o_tx_done(done_a), .o_busy(busy_a)
  );

  tx_uart #(.DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_tx_start(start_b),
    .i_data(data_b), .o_tx(tx_b), .o_tx_done(done_b), .o_busy(busy_b)
  );

  assign tx_s   = sel_b ? tx_b   : tx_a;
  assign done_s = sel_b ? done_b : done_a;
  assign busy_s = sel_b ? busy_b : busy_a;

  always #5 clk = ~clk;

  // Tick strobe one clock wide, every 4 clocks, changing on the falling edge.
  always @(negedge clk) begin
    tcnt = (tcnt == 3) ? 0 : tcnt + 1;
    tick = (tcnt == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n tick edges; returns 1 time unit after the last one.
  task automatic wait_ticks(input int n);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < 1000) begin
      @(posedge clk);
      cyc++;
      if (tick) seen++;
    end
    #1;
    if (seen < n) begin
      compared++;
      mismatched++;
      $display("FAIL tick_timeout: observed %0d ticks expected %0d", seen, n);
    end
  endtask

  task automatic set_start(input logic v, input logic [7:0] d);
    if (sel_b) begin start_b = v; data_b = d[6:0]; end
    else       begin start_a = v; data_a = d;      end
  endtask

  // Sends (or continues, when skip_accept) one frame and checks every bit
  // mid-period, the done pulse on the final tick, and an optional chained start.
  task automatic run_frame(input logic [7:0] d, input int nd, input int ns,
                           input bit skip_accept, input int poke_bit,
                           input bit chain, input logic [7:0] chain_d);
    int periods = 1 + nd + ns;
    logic exp_bit;
    if (!skip_accept) begin
      set_start(1'b1, d);
      @(posedge clk); #1;
      set_start(1'b0, 8'h00);
      check("accept_tx", {31'd0, tx_s}, 32'd0);
      check("accept_busy", {31'd0, busy_s}, 32'd1);
    end
    for (int b = 0; b < periods; b++) begin
      if (b == 0) exp_bit = 1'b0;
      else if (b <= nd) exp_bit = d[b-1];
      else exp_bit = 1'b1;
      wait_ticks(8);
      check($sformatf("bit%0d_tx_%02h", b, d), {31'd0, tx_s}, {31'd0, exp_bit});
      if (b == poke_bit) begin
        set_start(1'b1, 8'h3C);
        @(posedge clk); #1;
        set_start(1'b0, 8'h00);
      end
      if (b == periods - 1) begin
        wait_ticks(7);
        check("pre_done", {31'd0, done_s}, 32'd0);
        check("pre_done_busy", {31'd0, busy_s}, 32'd1);
        if (chain) set_start(1'b1, chain_d);
        wait_ticks(1);
        check("done_pulse", {31'd0, done_s}, 32'd1);
        check("done_busy", {31'd0, busy_s}, 32'd0);
        check("done_tx", {31'd0, tx_s}, 32'd1);
      end else begin
        wait_ticks(8);
      end
    end
    @(posedge clk); #1;
    check("done_clear", {31'd0, done_s}, 32'd0);
    if (chain) begin
      set_start(1'b0, 8'h00);
      check("chain_tx", {31'd0, tx_s}, 32'd0);
      check("chain_busy", {31'd0, busy_s}, 32'd1);
    end else begin
      check("idle_tx", {31'd0, tx_s}, 32'd1);
      check("idle_busy", {31'd0, busy_s}, 32'd0);
    end
  endtask

  initial begin
    logic [7:0] rnd;
    rnd = 8'($urandom_range(0, 255));

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_a", {31'd0, tx_a}, 32'd1);
    check("rst_busy_a", {31'd0, busy_a}, 32'd0);
    check("rst_done_a", {31'd0, done_a}, 32'd0);
    check("rst_tx_b", {31'd0, tx_b}, 32'd1);
    check("rst_busy_b", {31'd0, busy_b}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 8N1 frames, including a mid-frame start request that must be dropped.
    sel_b = 1'b0;
    run_frame(8'hA5, 8, 1, 1'b0, -1, 1'b0, 8'h00);
    $display("frame 8N1 data=A5 done");
    run_frame(8'h00, 8, 1, 1'b0, -1, 1'b0, 8'h00);
    $display("frame 8N1 data=00 done");
    run_frame(8'hFF, 8, 1, 1'b0, -1, 1'b0, 8'h00);
    $display("frame 8N1 data=FF done");
    run_frame(8'h55, 8, 1, 1'b0, -1, 1'b0, 8'h00);
    $display("frame 8N1 data=55 done");
    run_frame(rnd, 8, 1, 1'b0, -1, 1'b0, 8'h00);
    $display("frame 8N1 data=%02h (random) done", rnd);
    run_frame(8'hA5, 8, 1, 1'b0, 3, 1'b0, 8'h00);
    $display("frame 8N1 data=A5 with ignored 3C request done");

    // Back-to-back: start held across the done pulse, second frame follows at once.
    run_frame(8'h5A, 8, 1, 1'b0, -1, 1'b1, 8'h81);
    run_frame(8'h81, 8, 1, 1'b1, -1, 1'b0, 8'h00);
    $display("frame 8N1 back-to-back 5A then 81 done");

    // Reset during data bit 4 abandons the frame without a done pulse.
    set_start(1'b1, 8'hC3);
    @(posedge clk); #1;
    set_start(1'b0, 8'h00);
    wait_ticks(16 * 5 + 8);
    check("pre_rst_tx", {31'd0, tx_a}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_tx", {31'd0, tx_a}, 32'd1);
    check("midrst_busy", {31'd0, busy_a}, 32'd0);
    check("midrst_done", {31'd0, done_a}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_frame(8'h96, 8, 1, 1'b0, -1, 1'b0, 8'h00);
    $display("frame 8N1 data=96 after mid-frame reset done");

    // 7 data bits, 2 stop bits: 32-tick stop, 160 ticks in total.
    sel_b = 1'b1;
    run_frame(8'h41, 7, 2, 1'b0, -1, 1'b0, 8'h00);
    $display("frame 7N2 data=41 done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
